// File: rtl/c_alu_operand_fifo.sv
// ---------------------------------------------------------------------------
// c_alu_operand_fifo
//
// This block buffers operand and control bundles for the structural Hack ALU.
// It accepts {x, y, zx, nx, zy, ny, f, no} bundles from the CPU decode stage
// over a valid/ready handshake. It hands them to the ALU input stage one per
// transfer, in order and without loss.
//
// The outputs are first-word-fall-through and registered. The head bundle sits
// in its own register, which is loaded on the clock edge with whatever will be
// the head after that edge. Input data therefore never passes combinationally
// to the outputs. While the buffer is empty, the head register keeps its last
// value. After reset it holds 0.
//
// Ports:
//   clk              sole clock, rising edge
//   reset_n          asynchronous active-low reset
//   in_valid         upstream offers a bundle
//   in_ready         buffer can accept (= count != DEPTH)
//   in_x, in_y       16-bit ALU operands
//   in_ctrl          {zx,nx,zy,ny,f,no}, bit 5 = zx
//   out_valid        head bundle available (= count != 0)
//   out_ready        ALU stage consumes the head
//   out_x, out_y     head operands (registered)
//   out_ctrl         head control bits (registered)
//   count            occupancy, 0..DEPTH
//   overflow_sticky  in_valid was seen while full; cleared only by reset
// ---------------------------------------------------------------------------
module c_alu_operand_fifo #(
    parameter int DEPTH = 4,   // power of two, 2..16
    parameter int PTR_W = 2    // log2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic [5:0]       in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_x,
    output logic [15:0]      out_y,
    output logic [5:0]       out_ctrl,
    output logic [PTR_W:0]   count,
    output logic             overflow_sticky
);

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctrl;
    } bundle_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    bundle_t          mem [DEPTH];
    bundle_t          in_bundle;
    bundle_t          head_q;
    bundle_t          head_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count_nxt;
    logic             push;
    logic             pop;

    assign in_bundle = {in_x, in_y, in_ctrl};

    // Both handshake flags come from the registered count only, so neither
    // port has a combinational path to the other side.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_x     = head_q.x;
    assign out_y     = head_q.y;
    assign out_ctrl  = head_q.ctrl;

    // Next occupancy and next head. The new head can be the bundle being
    // written on this edge. That happens when the buffer drains to that slot
    // or was empty. In that case the head comes from the input, not from the
    // memory, which is not written until the same edge.
    always_comb begin
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        head_nxt   = head_q;

        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_nxt = count + (PTR_W+1)'(1);
            2'b01:   count_nxt = count - (PTR_W+1)'(1);
            default: count_nxt = count;
        endcase

        if (count_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                head_nxt = in_bundle;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // NOTE: the storage array has no reset. Its contents are don't-care until
    // written, and leaving it unreset lets it map onto plain flops or RAM.
    // Every observable output comes from the reset head register instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_bundle;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the always_comb above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            head_q          <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            head_q <= head_nxt;
            if (in_valid && (count == FULL_COUNT)) begin
                overflow_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c_alu_operand_fifo.sv
// ---------------------------------------------------------------------------
// tb_c_alu_operand_fifo
//
// Directed vectors with hand-computed expectations for c_alu_operand_fifo
// (DEPTH=4), followed by constrained-random traffic against a queue model.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled at
// the same point, before the next edge.
// ---------------------------------------------------------------------------
module tb_c_alu_operand_fifo;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_x;
    logic [15:0]      in_y;
    logic [5:0]       in_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_x;
    logic [15:0]      out_y;
    logic [5:0]       out_ctrl;
    logic [PTR_W:0]   count;
    logic             overflow_sticky;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    c_alu_operand_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_x            (in_x),
        .in_y            (in_y),
        .in_ctrl         (in_ctrl),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_ctrl        (out_ctrl),
        .count           (count),
        .overflow_sticky (overflow_sticky)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Derived y/ctrl so every field of a directed bundle is distinct.
    function automatic logic [37:0] mk(input logic [15:0] x);
        return {x, x ^ 16'h5A5A, x[5:0] ^ 6'b101010};
    endfunction

    task automatic drive(input logic v, input logic [15:0] x);
        logic [37:0] b;
        b        = mk(x);
        in_valid = v;
        in_x     = b[37:22];
        in_y     = b[21:6];
        in_ctrl  = b[5:0];
    endtask

    function automatic logic [37:0] head();
        return {out_x, out_y, out_ctrl};
    endfunction

    initial begin
        logic [37:0] q[$];
        logic [37:0] prev_head;
        logic        prev_hold;
        logic        exp_ovf;
        logic        m_push;
        logic        m_pop;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_count",     count, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  head(), 0);
        check("rst_ovf",       overflow_sticky, 0);
        #1 reset_n = 1'b1;
        tick();

        // ---- single push, FWFT latency of one edge ----
        in_valid = 1'b1;
        in_x     = 16'h1234;
        in_y     = 16'h00FF;
        in_ctrl  = 6'b010011;
        tick();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_x",     out_x, 16'h1234);
        check("single_y",     out_y, 16'h00FF);
        check("single_ctrl",  out_ctrl, 6'b010011);
        check("single_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drained", count, 0);
        check("single_hold_x",  out_x, 16'h1234);

        // ---- fill to full, overflow attempt, pop while full ----
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'(i));
            tick();
        end
        drive(1'b0, 16'h0);
        check("full_count",    count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_ovf_pre",  overflow_sticky, 0);
        check("full_head",     head(), mk(16'd1));
        drive(1'b1, 16'd5);
        tick();
        drive(1'b0, 16'h0);
        check("ovf_set",      overflow_sticky, 1);
        check("ovf_count",    count, 4);
        check("ovf_head",     head(), mk(16'd1));
        // Full with in_valid and out_ready: pop only, x=5 still rejected.
        drive(1'b1, 16'd5);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 16'h0);
        check("fullpop_count", count, 3);
        check("fullpop_ready", in_ready, 1);
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), head(), mk(16'(i)));
            tick();
        end
        check("drain_empty", out_valid, 0);
        check("drain_count", count, 0);
        out_ready = 1'b0;

        // ---- steady push+pop at count=2 across pointer wrap ----
        drive(1'b1, 16'h0100);
        tick();
        drive(1'b1, 16'h0101);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'(16'h0102 + k));
            check($sformatf("stream_head_%0d", k), head(), mk(16'(16'h0100 + k)));
            check($sformatf("stream_cnt_%0d", k), count, 2);
            tick();
        end
        drive(1'b0, 16'h0);
        check("stream_end_count", count, 2);
        check("stream_end_h0", head(), mk(16'h010A));
        tick();
        check("stream_end_h1", head(), mk(16'h010B));
        tick();

        // ---- empty with out_ready=1: nothing moves, outputs hold ----
        for (int k = 0; k < 5; k++) begin
            check($sformatf("empty_valid_%0d", k), out_valid, 0);
            check($sformatf("empty_cnt_%0d", k), count, 0);
            check($sformatf("empty_hold_%0d", k), head(), mk(16'h010B));
            tick();
        end
        out_ready = 1'b0;
        drive(1'b1, 16'hBEEF);
        tick();
        drive(1'b0, 16'h0);
        check("after_empty_valid", out_valid, 1);
        check("after_empty_head",  head(), mk(16'hBEEF));
        check("after_empty_count", count, 1);

        // ---- asynchronous reset mid-operation at count=3 ----
        drive(1'b1, 16'hC001);
        tick();
        drive(1'b1, 16'hC002);
        tick();
        drive(1'b0, 16'h0);
        check("pre_reset_count", count, 3);
        #1 reset_n = 1'b0;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_count", count, 0);
        check("areset_ready", in_ready, 1);
        check("areset_data",  head(), 0);
        check("areset_ovf",   overflow_sticky, 0);
        #1 reset_n = 1'b1;
        tick();
        check("post_reset_valid", out_valid, 0);

        // ---- random traffic against a queue model ----
        exp_ovf   = 1'b0;
        prev_hold = 1'b0;
        prev_head = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_x      = 16'($urandom);
            in_y      = 16'($urandom);
            in_ctrl   = 6'($urandom);

            check("rnd_count",     count, q.size());
            check("rnd_out_valid", out_valid, q.size() != 0);
            check("rnd_in_ready",  in_ready, q.size() < DEPTH);
            check("rnd_ovf",       overflow_sticky, exp_ovf);
            if (q.size() != 0) begin
                check("rnd_head", head(), q[0]);
            end
            if (prev_hold) begin
                check("rnd_stable", head(), prev_head);
            end

            m_push    = in_valid && (q.size() < DEPTH);
            m_pop     = out_ready && (q.size() != 0);
            prev_hold = (q.size() != 0) && !out_ready;
            prev_head = head();
            if (in_valid && q.size() == DEPTH) begin
                exp_ovf = 1'b1;
            end
            if (m_pop) begin
                void'(q.pop_front());
            end
            if (m_push) begin
                q.push_back({in_x, in_y, in_ctrl});
            end
            tick();
        end
        check("rnd_final_count", count, q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
